// File: rtl/force_release_ctrl.sv
// Force/release controller: q follows d_in on d_vld until a force request pins it to
// frc_val for a bounded number of cycles. Define FRC_SHADOW_EN to restore shadowed data on release.
module force_release_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] d_in,
  input  logic             d_vld,
  input  logic             frc_req,
  input  logic [WIDTH-1:0] frc_val,
  input  logic [CNT_W-1:0] frc_cycles,
  input  logic             rel_req,
  output logic             frc_ack,
  output logic [WIDTH-1:0] q,
  output logic             forced,
  output logic             rel_done
);

  typedef enum logic [1:0] {
    IDLE,
    FORCE,
    RELEASE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_init;

  // A zero hold length still forces for one cycle.
  assign cnt_init = (frc_cycles == '0) ? CNT_W'(1) : frc_cycles;

`ifdef FRC_SHADOW_EN
  logic [WIDTH-1:0] shadow;
`endif

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      q        <= '0;
      cnt      <= '0;
      forced   <= 1'b0;
      frc_ack  <= 1'b0;
      rel_done <= 1'b0;
`ifdef FRC_SHADOW_EN
      shadow   <= '0;
`endif
    end else begin
      frc_ack  <= 1'b0;
      rel_done <= 1'b0;
      case (state)
        IDLE: begin
          if (frc_req) begin
            frc_ack <= 1'b1;
            q       <= frc_val;
            cnt     <= cnt_init;
            forced  <= 1'b1;
            state   <= FORCE;
`ifdef FRC_SHADOW_EN
            shadow  <= q;
`endif
          end else if (d_vld) begin
            q <= d_in;
          end
        end

        FORCE: begin
`ifdef FRC_SHADOW_EN
          if (d_vld) shadow <= d_in;
`endif
          // The counter exits at 1 and never decrements past it.
          if (cnt <= CNT_W'(1) || rel_req) begin
            forced   <= 1'b0;
            rel_done <= 1'b1;
            state    <= RELEASE;
`ifdef FRC_SHADOW_EN
            q        <= d_vld ? d_in : shadow;
`endif
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        RELEASE: begin
          state <= IDLE;
          if (d_vld) q <= d_in;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_force_release_ctrl.sv
// Directed bench for force_release_ctrl; expectations follow FRC_SHADOW_EN when defined.
module tb_force_release_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] d_in;
  logic       d_vld;
  logic       frc_req;
  logic [7:0] frc_val;
  logic [7:0] frc_cycles;
  logic       rel_req;
  logic       frc_ack;
  logic [7:0] q;
  logic       forced;
  logic       rel_done;

  int n_checks = 0;
  int n_pass   = 0;

  force_release_ctrl #(.WIDTH(8), .CNT_W(8)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .d_in      (d_in),
    .d_vld     (d_vld),
    .frc_req   (frc_req),
    .frc_val   (frc_val),
    .frc_cycles(frc_cycles),
    .rel_req   (rel_req),
    .frc_ack   (frc_ack),
    .q         (q),
    .forced    (forced),
    .rel_done  (rel_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0; d_in = '0; d_vld = 1'b0; frc_req = 1'b0;
    frc_val = '0; frc_cycles = '0; rel_req = 1'b0;
    step(); step();
    check("rst_q", q, 0);
    check("rst_forced", forced, 0);
    check("rst_ack", frc_ack, 0);
    check("rst_rel_done", rel_done, 0);
    rstn = 1'b1;

    // Normal load and hold
    d_vld = 1'b1; d_in = 8'h5A;
    step();
    d_vld = 1'b0; d_in = 8'h77;
    check("load_q", q, 8'h5A);
    check("load_forced", forced, 0);
    step();
    check("hold_q", q, 8'h5A);

    // Force C3 for 3 cycles
    frc_req = 1'b1; frc_val = 8'hC3; frc_cycles = 8'd3;
    step();
    frc_req = 1'b0;
    check("f3_ack", frc_ack, 1);
    check("f3_q", q, 8'hC3);
    check("f3_forced0", forced, 1);
    step();
    check("f3_ack_pulse", frc_ack, 0);
    check("f3_forced1", forced, 1);
    check("f3_q1", q, 8'hC3);
    step();
    check("f3_forced2", forced, 1);
    check("f3_rd_early", rel_done, 0);
    step();
    check("f3_forced3", forced, 0);
    check("f3_rel_done", rel_done, 1);
`ifdef FRC_SHADOW_EN
    check("f3_q_rel", q, 8'h5A);
`else
    check("f3_q_rel", q, 8'hC3);
`endif
    step();
    check("f3_rd_pulse", rel_done, 0);

    // Force wins over d_vld; data during force
    frc_req = 1'b1; frc_val = 8'hFF; frc_cycles = 8'd3; d_vld = 1'b1; d_in = 8'hAA;
    step();
    frc_req = 1'b0; d_in = 8'h11;
    check("ff_ack", frc_ack, 1);
    check("ff_q_wins", q, 8'hFF);
    step();
    d_vld = 1'b0;
    check("ff_q_held", q, 8'hFF);
    step();
    check("ff_forced", forced, 1);
    step();
    check("ff_rel_done", rel_done, 1);
`ifdef FRC_SHADOW_EN
    check("ff_q_rel", q, 8'h11);
`else
    check("ff_q_rel", q, 8'hFF);
`endif
    step();
`ifdef FRC_SHADOW_EN
    check("ff_q_idle", q, 8'h11);
`else
    check("ff_q_idle", q, 8'hFF);
`endif

    // Early release at 2nd forced cycle
    frc_req = 1'b1; frc_val = 8'h3C; frc_cycles = 8'd10;
    step();
    frc_req = 1'b0;
    check("er_ack", frc_ack, 1);
    step();
    rel_req = 1'b1;
    check("er_forced2", forced, 1);
    step();
    rel_req = 1'b0;
    check("er_forced", forced, 0);
    check("er_rel_done", rel_done, 1);
    step();
    check("er_rd_pulse", rel_done, 0);

    // rel_req in IDLE is ignored
    rel_req = 1'b1;
    step();
    rel_req = 1'b0;
    check("idle_rel_rd", rel_done, 0);
    check("idle_rel_forced", forced, 0);

    // Zero length, frc_req held through RELEASE, d_vld in RELEASE loads
    frc_req = 1'b1; frc_val = 8'h81; frc_cycles = 8'd0;
    step();
    check("z_ack", frc_ack, 1);
    check("z_forced", forced, 1);
    step();
    d_vld = 1'b1; d_in = 8'h42;
    check("z_rel_forced", forced, 0);
    check("z_rel_done", rel_done, 1);
    check("z_no_ack_rel", frc_ack, 0);
    step();
    d_vld = 1'b0;
    check("z_no_ack_idle", frc_ack, 0);
    check("z_rel_load", q, 8'h42);
    step();
    frc_req = 1'b0;
    check("z_ack2", frc_ack, 1);
    check("z_forced2", forced, 1);
    step();
    check("z_rel_done2", rel_done, 1);
    step();

    // Reset mid-force
    frc_req = 1'b1; frc_val = 8'hE7; frc_cycles = 8'd5;
    step();
    frc_req = 1'b0;
    step();
    check("mr_forced_pre", forced, 1);
    rstn = 1'b0;
    #1;
    check("mr_q", q, 0);
    check("mr_forced", forced, 0);
    check("mr_rd0", rel_done, 0);
    step();
    check("mr_rd1", rel_done, 0);
    rstn = 1'b1;
    step();
    check("mr_rd2", rel_done, 0);
    check("mr_forced2", forced, 0);
    d_vld = 1'b1; d_in = 8'h99;
    step();
    d_vld = 1'b0;
    check("mr_load", q, 8'h99);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
